mem_arbiter: RTL and testbench

Shares the single-ported unified RAM between the instruction-fetch port (IF) and the load/store port (D) of the MIPS core. Arbitrates one access at a time, sequences the fixed RAM latency, and returns read data or a write acknowledge to the winning requester. Supports halfword stores, and cancels an in-flight fetch on a taken branch or jump. Sits between the fetch/memory stages and the RAM macro.

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch (IF) and load/store (D).
// One access in flight at a time; D has priority with bounded IF starvation.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_half,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_half,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic              owner_if;
    logic              we;
    logic              half;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t     state_q, state_d;
  req_t       req_q, req_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] starve_q, starve_d;
  logic       kill_q, kill_d;

  logic idle, starve_full, d_win, resp;

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  assign idle        = (state_q == IDLE) & rst_n;
  assign starve_full = (starve_q == STARVE_LIM);
  assign d_win       = d_req & ~(if_req & starve_full);
  assign d_gnt       = idle & d_win;
  assign if_gnt      = idle & if_req & ~d_win;

  // Response lands MEM_LAT cycles after the grant; with MEM_LAT=1 that is ISSUE itself.
  assign resp = (MEM_LAT == 1) ? (state_q == ISSUE)
                               : ((state_q == WAIT) && (cnt_q == 4'd1));

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    kill_d   = kill_q;
    unique case (state_q)
      IDLE: begin
        if (if_gnt || d_gnt) begin
          state_d        = ISSUE;
          req_d.owner_if = if_gnt;
          req_d.addr     = if_gnt ? if_addr : d_addr;
          req_d.we       = d_gnt & d_we;
          req_d.half     = d_gnt & d_half;
          req_d.wdata    = d_gnt ? d_wdata : '0;
          kill_d         = if_gnt & flush;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = (MEM_LAT == 1) ? IDLE : WAIT;
        kill_d  = kill_q | (req_q.owner_if & flush);
      end
      WAIT: begin
        cnt_d  = 4'(cnt_q - 4'd1);
        kill_d = kill_q | (req_q.owner_if & flush);
        if (cnt_q == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) kill_d = 1'b0;

    // Count D wins while IF is waiting; any IF win or uncontested D win resets it.
    if (d_gnt) begin
      if (!if_req)                    starve_d = '0;
      else if (starve_q < STARVE_LIM) starve_d = 4'(starve_q + 4'd1);
    end else if (if_gnt) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      kill_q   <= kill_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en & req_q.we & ~req_q.owner_if;
  assign mem_half  = mem_we & req_q.half;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  // A flush raised in the response cycle itself must still hide the data.
  assign if_rvalid = resp & req_q.owner_if & ~(kill_q | flush);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rvalid  = resp & ~req_q.owner_if;
  assign d_rdata   = (d_rvalid & ~req_q.we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed test-plan steps, then random traffic,
// all compared every cycle against a transaction-timed reference model.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, LAT = 2, SMAX = 4;

  logic          clk = 0, rst_n = 1;
  logic          if_req = 0, flush = 0, d_req = 0, d_we = 0, d_half = 0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, mem_half, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .flush(flush),
    .d_req(d_req), .d_we(d_we), .d_half(d_half), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_half(mem_half), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return {a[15:0] ^ 16'hC3A5, a[31:16]};
  endfunction

  // RAM model: the word addressed at the enable cycle is presented until the next enable.
  logic [AW-1:0] ram_addr = '0;
  always @(posedge clk) if (mem_en) ram_addr <= mem_addr;
  assign mem_rdata = rd_val(ram_addr);

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a transaction occupies [grant, grant+LAT]; response at grant+LAT.
  int          cyc = 0, m_free = 0, m_grant = -100, m_starve = 0;
  bit          m_if = 0, m_we = 0, m_half = 0, m_killed = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  bit          d_stream = 0;
  // Event log
  int          n_ig = 0, n_dg = 0, n_irv = 0, n_drv = 0, gi_cyc = 0, gd_cyc = 0, last_grant_if = 0;
  logic [31:0] last_ird = '0, last_drd = '0, cap_addr = '0, cap_wdata = '0;
  logic        cap_we = 0, cap_half = 0;

  task automatic cycle();
    bit active, e_ig, e_dg, e_en, e_we, resp, e_irv, e_drv;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_outs", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_half, busy}, '0);
      chk("rst_data", {if_rdata, d_rdata}, '0);
      chk("rst_bus", {mem_addr, mem_wdata}, '0);
      m_free = cyc; m_grant = -100; m_starve = 0; m_killed = 0;
      m_if = 0; m_we = 0; m_half = 0; m_addr = '0; m_wdata = '0;
    end else begin
      active = cyc < m_free;
      e_dg   = !active && d_req && !(if_req && m_starve == SMAX);
      e_ig   = !active && if_req && !e_dg;
      e_en   = active && cyc == m_grant + 1;
      e_we   = e_en && !m_if && m_we;
      resp   = active && cyc == m_grant + LAT;
      e_irv  = resp && m_if && !(m_killed || flush);
      e_drv  = resp && !m_if;
      chk("if_gnt", if_gnt, e_ig);
      chk("d_gnt", d_gnt, e_dg);
      chk("busy", busy, active);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      chk("mem_half", mem_half, e_we && m_half);
      chk("mem_addr", mem_addr, m_addr);
      if (e_we) chk("mem_wdata", mem_wdata, m_wdata);
      chk("if_rvalid", if_rvalid, e_irv);
      chk("if_rdata", if_rdata, e_irv ? rd_val(m_addr) : 32'h0);
      chk("d_rvalid", d_rvalid, e_drv);
      chk("d_rdata", d_rdata, (e_drv && !m_we) ? rd_val(m_addr) : 32'h0);
      if (if_gnt) begin n_ig++; gi_cyc = cyc; last_grant_if = 1; end
      if (d_gnt)  begin n_dg++; gd_cyc = cyc; last_grant_if = 0; end
      if (if_rvalid) begin n_irv++; last_ird = if_rdata; end
      if (d_rvalid)  begin n_drv++; last_drd = d_rdata; end
      if (mem_en) begin cap_we = mem_we; cap_half = mem_half; cap_addr = mem_addr; cap_wdata = mem_wdata; end
      if (e_ig || e_dg) begin
        m_grant = cyc; m_free = cyc + LAT + 1; m_if = e_ig;
        m_addr  = e_ig ? if_addr : d_addr;
        m_we    = e_dg && d_we; m_half = e_dg && d_half;
        m_wdata = e_dg ? d_wdata : 32'h0;
        m_killed = e_ig && flush;
        if (e_ig) m_starve = 0;
        else if (if_req) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
        else m_starve = 0;
      end else if (active && m_if && flush) m_killed = 1;
    end
    @(posedge clk); cyc++; #1;
    if (e_ig) if_req = 0;
    if (e_dg && !d_stream) d_req = 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int base_irv, base_drv, nd_before;

  initial begin
    // Reset state
    #1 rst_n = 0;
    cycles(2);
    rst_n = 1;
    cycle();

    // IF read of 0x0040_0000
    if_req = 1; if_addr = 32'h0040_0000;
    cycles(4);
    chk("tp_if_rdata", last_ird, 32'h2008_0005);
    chk("tp_if_addr", cap_addr, 32'h0040_0000);

    // Simultaneous IF and D load: D first, IF three cycles later
    if_req = 1; if_addr = 32'h0040_0004;
    d_req = 1; d_we = 0; d_half = 0; d_addr = 32'h1000_0010;
    cycles(7);
    chk("tp_gnt_gap", gi_cyc - gd_cyc, 3);
    chk("tp_d_rdata", last_drd, rd_val(32'h1000_0010));
    chk("tp_if_rdata2", last_ird, rd_val(32'h0040_0004));

    // Starvation bound: D streams while IF waits
    nd_before = n_dg;
    d_stream = 1; d_req = 1; d_addr = 32'h1000_0020;
    if_req = 1; if_addr = 32'h0040_0008;
    for (int i = 0; i < 40 && if_req; i++) cycle();
    chk("starve_d_grants", n_dg - nd_before, SMAX);
    chk("starve_if_won", last_grant_if, 1);
    cycles(LAT + 2);
    chk("starve_d_again", last_grant_if, 0);
    d_stream = 0; d_req = 0;
    cycles(LAT + 1);

    // Halfword store
    base_drv = n_drv;
    d_req = 1; d_we = 1; d_half = 1; d_addr = 32'h0000_0100; d_wdata = 32'h0000_ABCD;
    cycles(4);
    chk("hs_strobes", {cap_we, cap_half}, 2'b11);
    chk("hs_addr", cap_addr, 32'h0000_0100);
    chk("hs_wdata", cap_wdata, 32'h0000_ABCD);
    chk("hs_ack", n_drv - base_drv, 1);
    chk("hs_rdata", last_drd, 0);
    d_we = 0; d_half = 0;

    // Flush at T+1 suppresses the fetch; next fetch returns normally
    base_irv = n_irv;
    if_req = 1; if_addr = 32'h0040_0010;
    cycle();
    flush = 1; cycle();
    flush = 0; cycle();
    chk("fl_suppressed", n_irv - base_irv, 0);
    if_req = 1; if_addr = 32'h0040_0014;
    cycles(4);
    chk("fl_next_ok", n_irv - base_irv, 1);
    chk("fl_next_data", last_ird, rd_val(32'h0040_0014));

    // Reset during WAIT of a D load
    base_drv = n_drv;
    d_req = 1; d_addr = 32'h1000_0030;
    cycles(2);
    rst_n = 0;
    cycle();
    rst_n = 1;
    d_req = 1; d_addr = 32'h1000_0034;
    cycle();
    chk("rst_regrant", gd_cyc, cyc - 1);
    cycles(3);
    chk("rst_no_stale", n_drv - base_drv, 1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = {$urandom_range(0, 255), 2'b00};
      end
      if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1; d_we = $urandom_range(0, 1); d_half = $urandom_range(0, 1);
        d_addr = $urandom; d_wdata = $urandom;
      end
      flush = ($urandom_range(0, 5) == 0);
      cycle();
    end
    if_req = 0; d_req = 0; flush = 0;
    cycles(LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
